// File: rtl/hamming15_pkg.sv
// hamming15_pkg: shared widths, data-position map, parity masks and FIFO occupancy enum
package hamming15_pkg;
    localparam int DATA_W = 11;
    localparam int CODE_W = 16;
    localparam logic [3:0] DATA_POS [DATA_W] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    // Codeword positions covered by p1, p2, p4, p8 (data positions only)
    localparam logic [CODE_W-1:0] P1_MASK = 16'hAAA8;
    localparam logic [CODE_W-1:0] P2_MASK = 16'hCCC8;
    localparam logic [CODE_W-1:0] P4_MASK = 16'hF0E0;
    localparam logic [CODE_W-1:0] P8_MASK = 16'hFE00;
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;
endpackage

// File: rtl/hamming15_enc_core.sv
// hamming15_enc_core: combinational Hamming(15,11) encoder, bit 0 optionally carries even overall parity
module hamming15_enc_core
    import hamming15_pkg::*;
#(
    parameter bit OVERALL_PARITY = 1'b1
) (
    input  logic [DATA_W-1:0] data_in,
    output logic [CODE_W-1:0] code_out
);
    logic [CODE_W-1:0] w_data_pos;
    logic [CODE_W-1:0] w_code_hi;
    always_comb begin
        w_data_pos = '0;
        for (int i = 0; i < DATA_W; i++) w_data_pos[DATA_POS[i]] = data_in[i];
    end
    always_comb begin
        w_code_hi    = w_data_pos;
        w_code_hi[1] = ^(w_data_pos & P1_MASK);
        w_code_hi[2] = ^(w_data_pos & P2_MASK);
        w_code_hi[4] = ^(w_data_pos & P4_MASK);
        w_code_hi[8] = ^(w_data_pos & P8_MASK);
    end
    assign code_out = {w_code_hi[CODE_W-1:1], OVERALL_PARITY ? ^w_code_hi[CODE_W-1:1] : 1'b0};
endmodule

// File: rtl/hamming15_enc.sv
// hamming15_enc: valid/ready Hamming(15,11) encoder with a 2-entry output FIFO and delivery counter
module hamming15_enc
    import hamming15_pkg::*;
#(
    parameter bit OVERALL_PARITY = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CODE_W-1:0] code_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        enc_count
);
    occ_e              r_occ;
    logic [CODE_W-1:0] r_head;
    logic [CODE_W-1:0] r_tail;
    logic [7:0]        r_count;
    logic [CODE_W-1:0] w_code;
    logic              w_push;
    logic              w_pop;

    hamming15_enc_core #(.OVERALL_PARITY(OVERALL_PARITY)) u_core (
        .data_in  (data_in),
        .code_out (w_code)
    );

    // in_ready is gated by reset_n so it reads 0 while reset is held
    assign in_ready  = reset_n && (r_occ != OCC_TWO);
    assign out_valid = r_occ != OCC_EMPTY;
    assign code_out  = r_head;
    assign enc_count = r_count;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_occ   <= OCC_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) r_count <= r_count + 8'd1;
            case (r_occ)
                OCC_EMPTY: if (w_push) begin
                    r_head <= w_code;
                    r_occ  <= OCC_ONE;
                end
                OCC_ONE: begin
                    if (w_push && w_pop) r_head <= w_code;
                    if (w_push && !w_pop) r_tail <= w_code;
                    if (w_push != w_pop) r_occ <= w_push ? OCC_TWO : OCC_EMPTY;
                end
                OCC_TWO: if (w_pop) begin
                    r_head <= r_tail;
                    r_occ  <= OCC_ONE;
                end
                default: r_occ <= OCC_EMPTY;
            endcase
        end
    end
endmodule
